ab_solver: RTL and testbench
============================

Name: ab_solver

Overview:
- Guessing side of the 1A2B (Bulls and Cows) game.
- Issues 4-digit BCD guesses with distinct digits to the scoring logic and consumes its {A,4'ha,B,4'hb} feedback word.
- Keeps a history of past guesses and feedback.
- Each new guess is the numerically smallest distinct-digit candidate consistent with every history entry.

Parameters:
- MAX_TRIES, 10, history depth and maximum number of guesses before fail (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new game; honoured only in IDLE, DONE or FAIL.
- guess  out  16  current guess, BCD digits [15:12],[11:8],[7:4],[3:0].
- guess_valid  out  1  high while guess is offered and awaiting feedback.
- fb  in  16  feedback word {A[3:0],4'ha,B[3:0],4'hb}.
- fb_valid  in  1  one-cycle pulse qualifying fb; sampled only while guess_valid=1.
- busy  out  1  high in SEARCH and OFFER.
- solved  out  1  high in DONE.
- fail  out  1  high in FAIL.
- tries  out  4  number of accepted feedback words in the current game.

Behaviour:
- Reset (any state, mid-search included): state=IDLE, guess=16'h0000, guess_valid=0, busy=0, solved=0, fail=0, tries=0, history count=0.
- States: IDLE, SEARCH, OFFER, DONE, FAIL.
- IDLE/DONE/FAIL + start:
  - Clear history and tries.
  - Load candidate 16'h0123 and check index idx=0.
  - Next state SEARCH; solved and fail drop the cycle after start.
- SEARCH, one evaluation per cycle, first matching rule applies:
  - Candidate has a repeated digit: BCD-increment candidate, idx=0.
  - idx==count: candidate accepted; guess<=candidate; go to OFFER; guess_valid=1 from the next cycle.
  - Score(candidate vs hist_guess[idx]) == hist_fb[idx]: idx++.
  - Otherwise: BCD-increment candidate, idx=0.
- Score definition: A = count of equal digits in equal positions; B = count of equal digits in different positions (12 cross compares). Compared as a full 16-bit word {A,4'ha,B,4'hb}.
- BCD increment: 4-digit decimal +1. Incrementing 16'h9876 or any larger value means the search is exhausted: go to FAIL, guess holds its last offered value.
- OFFER: guess and guess_valid held stable until valid feedback is accepted.
  - fb_valid with fb[11:8]!=4'ha, fb[3:0]!=4'hb, or A+B>4: malformed; ignored, remain in OFFER, tries unchanged.
  - Valid fb with A==4: tries++, go to DONE; guess held; guess_valid=0.
  - Other valid fb: store {guess, fb} at hist[count], count++, tries++.
    - If count now equals MAX_TRIES: go to FAIL.
    - Else BCD-increment candidate, idx=0, go to SEARCH.
- fb_valid outside OFFER: ignored.
- start outside IDLE/DONE/FAIL: ignored.
- DONE/FAIL: outputs hold until start or rst. busy=0 in both.
- Latency:
  - First guess appears 2 cycles after start.
  - Later guesses have data-dependent latency, bounded by roughly 10000 x (MAX_TRIES+1) cycles.
- Width rules: A, B, tries and idx are 4-bit. Score sums never exceed 4.

Test Plan:
1. Assert rst for 2 cycles, then release. Required: guess_valid=0, busy=0, solved=0, fail=0, tries=0, guess=16'h0000.
2. Answer 0123. Pulse start. Required: guess=16'h0123 with guess_valid=1 two cycles later. Return fb=16'h4a0b. Required: solved=1, tries=1, guess_valid=0.
3. Answer 4567.
   - Guess 0123 gets fb=16'h0a0b.
   - Required next guess: 16'h4567.
   - fb=16'h4a0b. Required: solved=1, tries=2.
4. Answer 1023.
   - Guess 0123 gets fb=16'h2a2b.
   - Required next guess: 16'h0132.
   - That guess gets fb=16'h0a4b. Required: the following guess is consistent with both history entries.
   - Bench model checks the solve within MAX_TRIES.
5. Contradictory feedback.
   - fb=16'h0a0b for 0123, then fb=16'h0a0b for 4567.
   - Required: search exhausts, fail=1, busy=0, tries=2.
   - Pulse start. Required: fail=0 and guess=16'h0123 offered again.
6. Robustness.
   - In OFFER, pulse fb_valid with 16'h3a2b and again with 16'h1c0b. Required: both ignored, guess_valid stays 1, tries unchanged.
   - Assert rst during SEARCH. Required: IDLE with all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ab_solver.sv
// Guessing side of the 1A2B (Bulls and Cows) game. Each guess is the smallest
// distinct-digit BCD candidate consistent with every past {guess, feedback} pair.
module ab_solver #(
  parameter int MAX_TRIES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] guess,
  output logic        guess_valid,
  input  logic [15:0] fb,
  input  logic        fb_valid,
  output logic        busy,
  output logic        solved,
  output logic        fail,
  output logic [3:0]  tries
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEARCH = 3'd1,
    S_OFFER  = 3'd2,
    S_DONE   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [3:0]  MAX_T4   = 4'(MAX_TRIES);
  localparam logic [15:0] CAND_LO  = 16'h0123;
  localparam logic [15:0] CAND_TOP = 16'h9876;

  function automatic logic has_repeat(input logic [15:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (v[i*4 +: 4] == v[j*4 +: 4]) r = 1'b1;
        else r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] score(input logic [15:0] c, input logic [15:0] h);
    logic [3:0] a;
    logic [3:0] b;
    a = 4'd0;
    b = 4'd0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (c[i*4 +: 4] != h[j*4 +: 4]) a = a;
        else if (i == j) a = a + 4'd1;
        else b = b + 4'd1;
      end
    end
    return {a, 4'ha, b, 4'hb};
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!carry) r = r;
      else if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
      else begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
        carry       = 1'b0;
      end
    end
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] cand_r, cand_s;
  logic [3:0]  idx_r, idx_s;
  logic [3:0]  count_r, count_s;
  logic [3:0]  tries_r, tries_s;
  logic [15:0] guess_r, guess_s;
  logic        gv_r, gv_s;
  logic        busy_r, solved_r, fail_r;
  logic        hist_we_s;
  logic        fb_bad_s;
  logic [15:0] hist_g_r  [MAX_TRIES];
  logic [15:0] hist_fb_r [MAX_TRIES];

  assign fb_bad_s = (fb[11:8] != 4'ha) || (fb[3:0] != 4'hb) ||
                    (({1'b0, fb[15:12]} + {1'b0, fb[7:4]}) > 5'd4);

  // Next-state logic: candidate search, offer/feedback handling, game control.
  always_comb begin
    state_s   = state_r;
    cand_s    = cand_r;
    idx_s     = idx_r;
    count_s   = count_r;
    tries_s   = tries_r;
    guess_s   = guess_r;
    gv_s      = gv_r;
    hist_we_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          count_s = 4'd0;
          tries_s = 4'd0;
          cand_s  = CAND_LO;
          idx_s   = 4'd0;
          gv_s    = 1'b0;
          state_s = S_SEARCH;
        end else begin
          state_s = state_r;
        end
      end
      S_SEARCH: begin
        if (has_repeat(cand_r) ||
            ((idx_r != count_r) && (score(cand_r, hist_g_r[idx_r]) != hist_fb_r[idx_r]))) begin
          idx_s = 4'd0;
          if (cand_r >= CAND_TOP) state_s = S_FAIL;
          else cand_s = bcd_inc(cand_r);
        end else if (idx_r == count_r) begin
          guess_s = cand_r;
          gv_s    = 1'b1;
          state_s = S_OFFER;
        end else begin
          idx_s = idx_r + 4'd1;
        end
      end
      S_OFFER: begin
        if (!fb_valid || fb_bad_s) begin
          state_s = S_OFFER;
        end else if (fb[15:12] == 4'd4) begin
          tries_s = tries_r + 4'd1;
          gv_s    = 1'b0;
          state_s = S_DONE;
        end else begin
          // Record the rejected guess, then resume searching past it
          hist_we_s = 1'b1;
          count_s   = count_r + 4'd1;
          tries_s   = tries_r + 4'd1;
          gv_s      = 1'b0;
          idx_s     = 4'd0;
          if ((count_r + 4'd1) == MAX_T4) state_s = S_FAIL;
          else if (cand_r >= CAND_TOP) state_s = S_FAIL;
          else begin
            cand_s  = bcd_inc(cand_r);
            state_s = S_SEARCH;
          end
        end
      end
      default: begin
        gv_s    = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cand_r   <= 16'h0000;
      idx_r    <= 4'd0;
      count_r  <= 4'd0;
      tries_r  <= 4'd0;
      guess_r  <= 16'h0000;
      gv_r     <= 1'b0;
      busy_r   <= 1'b0;
      solved_r <= 1'b0;
      fail_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cand_r   <= cand_s;
      idx_r    <= idx_s;
      count_r  <= count_s;
      tries_r  <= tries_s;
      guess_r  <= guess_s;
      gv_r     <= gv_s;
      busy_r   <= (state_s == S_SEARCH) || (state_s == S_OFFER);
      solved_r <= (state_s == S_DONE);
      fail_r   <= (state_s == S_FAIL);
    end
  end

  // History storage; entries beyond count_r are never read, so no reset needed.
  always_ff @(posedge clk) begin
    if (hist_we_s) begin
      hist_g_r[count_r]  <= guess_r;
      hist_fb_r[count_r] <= fb;
    end else begin
      hist_g_r[count_r]  <= hist_g_r[count_r];
      hist_fb_r[count_r] <= hist_fb_r[count_r];
    end
  end

  assign guess       = guess_r;
  assign guess_valid = gv_r;
  assign busy        = busy_r;
  assign solved      = solved_r;
  assign fail        = fail_r;
  assign tries       = tries_r;

endmodule

// File: tb/tb_ab_solver.sv
// Directed self-checking bench for ab_solver: table of full games plus
// hand-written sequences for exhaustion, malformed feedback and reset.
module tb_ab_solver;
  localparam int MAX_TRIES = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] guess;
  logic        guess_valid;
  logic [15:0] fb;
  logic        fb_valid;
  logic        busy;
  logic        solved;
  logic        fail;
  logic [3:0]  tries;

  int errors = 0;
  int checks = 0;

  ab_solver #(.MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst(rst), .start(start), .guess(guess), .guess_valid(guess_valid),
    .fb(fb), .fb_valid(fb_valid), .busy(busy), .solved(solved), .fail(fail), .tries(tries)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] ans;
    logic [15:0] g2;
    int          ntries;
  } game_t;

  game_t games [3];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_offer(input string name, input int budget);
    int n;
    n = 0;
    while (!guess_valid && n < budget) begin
      tick();
      n++;
    end
    chk(name, {15'd0, guess_valid}, 16'd1);
  endtask

  task automatic send_fb(input logic [15:0] w);
    fb       = w;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
    fb       = 16'h0000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference scorer: bulls by position, cows = common digits minus bulls.
  function automatic logic [15:0] ref_score(input logic [15:0] g, input logic [15:0] ans);
    int a, common;
    a = 0;
    common = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i*4 +: 4] == ans[i*4 +: 4]) a++;
      for (int j = 0; j < 4; j++)
        if (g[i*4 +: 4] == ans[j*4 +: 4]) common++;
    end
    return {4'(a), 4'ha, 4'(common - a), 4'hb};
  endfunction

  function automatic logic distinct(input logic [15:0] g);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < i; j++)
        if (g[i*4 +: 4] == g[j*4 +: 4]) ok = 1'b0;
    return ok;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_guess"}, guess, 16'h0000);
    chk({tag, "_gv"}, {15'd0, guess_valid}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_solved"}, {15'd0, solved}, 16'd0);
    chk({tag, "_fail"}, {15'd0, fail}, 16'd0);
    chk({tag, "_tries"}, {12'd0, tries}, 16'd0);
  endtask

  task automatic play(input game_t gm);
    logic [15:0] hg [$];
    logic [15:0] hf [$];
    logic [15:0] g, f;
    bit          done;
    pulse_start();
    chk("start_busy", {15'd0, busy}, 16'd1);
    chk("start_solved_drop", {15'd0, solved}, 16'd0);
    chk("start_gv_latency1", {15'd0, guess_valid}, 16'd0);
    tick();
    chk("first_gv", {15'd0, guess_valid}, 16'd1);
    chk("first_guess", guess, 16'h0123);
    done = 1'b0;
    for (int t = 0; t < MAX_TRIES && !done; t++) begin
      if (t > 0) wait_offer("next_offer", 30000);
      g = guess;
      chk("guess_distinct", {15'd0, distinct(g)}, 16'd1);
      for (int k = 0; k < hg.size(); k++)
        chk("guess_consistent", ref_score(g, hg[k]), hf[k]);
      if (t == 1) chk("second_guess", g, gm.g2);
      f = ref_score(g, gm.ans);
      send_fb(f);
      if (f[15:12] == 4'd4) begin
        done = 1'b1;
        chk("solved", {15'd0, solved}, 16'd1);
        chk("solved_gv", {15'd0, guess_valid}, 16'd0);
        chk("solved_busy", {15'd0, busy}, 16'd0);
        chk("solved_guess", guess, gm.ans);
        chk("solved_tries", {12'd0, tries}, 16'(gm.ntries));
      end else begin
        hg.push_back(g);
        hf.push_back(f);
      end
    end
    chk("game_finished", {15'd0, done}, 16'd1);
  endtask

  initial begin
    games[0] = '{ans: 16'h0123, g2: 16'h0000, ntries: 1};
    games[1] = '{ans: 16'h4567, g2: 16'h4567, ntries: 2};
    games[2] = '{ans: 16'h1023, g2: 16'h0132, ntries: 3};

    rst = 1'b1; start = 1'b0; fb_valid = 1'b0; fb = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_state("reset");

    for (int v = 0; v < 3; v++) play(games[v]);

    // Feedback while DONE must be ignored
    send_fb(16'h4a0b);
    chk("done_fb_ignored_tries", {12'd0, tries}, 16'd3);
    chk("done_hold_solved", {15'd0, solved}, 16'd1);

    // Contradictory feedback exhausts the search
    pulse_start();
    tick();
    chk("contra_g1", guess, 16'h0123);
    send_fb(16'h0a0b);
    wait_offer("contra_offer2", 30000);
    chk("contra_g2", guess, 16'h4567);
    send_fb(16'h0a0b);
    begin
      int n;
      n = 0;
      while (!fail && n < 40000) begin
        tick();
        n++;
      end
    end
    chk("exhaust_fail", {15'd0, fail}, 16'd1);
    chk("exhaust_busy", {15'd0, busy}, 16'd0);
    chk("exhaust_tries", {12'd0, tries}, 16'd2);
    chk("exhaust_gv", {15'd0, guess_valid}, 16'd0);
    chk("exhaust_guess_hold", guess, 16'h4567);
    pulse_start();
    chk("restart_fail_drop", {15'd0, fail}, 16'd0);
    tick();
    chk("restart_gv", {15'd0, guess_valid}, 16'd1);
    chk("restart_guess", guess, 16'h0123);
    chk("restart_tries", {12'd0, tries}, 16'd0);

    // Malformed feedback and stray start in OFFER
    send_fb(16'h3a2b);
    chk("bad_sum_gv", {15'd0, guess_valid}, 16'd1);
    chk("bad_sum_tries", {12'd0, tries}, 16'd0);
    send_fb(16'h1c0b);
    chk("bad_tag_gv", {15'd0, guess_valid}, 16'd1);
    chk("bad_tag_tries", {12'd0, tries}, 16'd0);
    chk("bad_tag_guess", guess, 16'h0123);
    pulse_start();
    chk("offer_start_ignored", {15'd0, guess_valid}, 16'd1);

    // Reset in the middle of a search
    send_fb(16'h0a0b);
    chk("search_busy", {15'd0, busy}, 16'd1);
    chk("search_gv", {15'd0, guess_valid}, 16'd0);
    chk("search_tries", {12'd0, tries}, 16'd1);
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("midreset");
    rst = 1'b0;
    tick();
    check_reset_state("post_midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
